// File: rtl/cnn_layer_accel_pkg.sv
// cnn_layer_accel_pkg
// Shared types and constants for the convolution-engine MACC sequencer:
//   slot_tag_e    - per-issue-cycle tag travelling alongside the DSP pipeline
//   seq_state_e   - sequencer FSM states
//   OPM_*         - DSP48E2 OPMODE encodings used by the sequencer
//   opmode_decode - maps a slot tag onto the OPMODE the slice must see
// Configuration macro: MACC_SEQ_BIAS_EN (FIRST slot also adds C through W).
package cnn_layer_accel_pkg;

  typedef enum logic [1:0] {
    TAG_NONE  = 2'd0,
    TAG_FIRST = 2'd1,
    TAG_ACC   = 2'd2,
    TAG_HOLD  = 2'd3
  } slot_tag_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_e;

  localparam logic [8:0] OPM_NONE  = 9'b000000000; // all muxes zero: clears P
  localparam logic [8:0] OPM_FIRST = 9'b000000101; // P = M
  localparam logic [8:0] OPM_ACC   = 9'b000100101; // P = P + M
  localparam logic [8:0] OPM_HOLD  = 9'b000100000; // P = P
  localparam logic [8:0] OPM_BIAS  = 9'b110000101; // P = C + M

  function automatic logic [8:0] opmode_decode(input slot_tag_e tag);
    logic [8:0] opm;
    case (tag)
`ifdef MACC_SEQ_BIAS_EN
      TAG_FIRST: opm = OPM_BIAS;
`else
      TAG_FIRST: opm = OPM_FIRST;
`endif
      TAG_ACC:   opm = OPM_ACC;
      TAG_HOLD:  opm = OPM_HOLD;
      TAG_NONE:  opm = OPM_NONE;
      default:   opm = OPM_NONE;
    endcase
    return opm;
  endfunction

endpackage

// File: rtl/cnn_layer_accel_macc_tag_pipe.sv
// cnn_layer_accel_macc_tag_pipe
// CE-gated delay line that shadows the DSP48E2 register stages.
//   clk, rst (sync, active-low), ce   - timing / freeze
//   tag_in, last_in, bias_in          - slot issued this cycle
//   tag_d2                            - tag aligned with A2/B2 (drives OPMODE)
//   last_d1..last_d4                  - last-slot marker at each depth;
//                                       depth 4 coincides with P holding it
//   bias_d3                           - bias aligned with the OPMODE register
// Configuration macro: MACC_SEQ_BIAS_EN (bias delay line present).
module cnn_layer_accel_macc_tag_pipe
  import cnn_layer_accel_pkg::*;
#(
  parameter int P_W = 48
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ce,
  input  slot_tag_e      tag_in,
  input  logic           last_in,
  input  logic [P_W-1:0] bias_in,
  output slot_tag_e      tag_d2,
  output logic           last_d1,
  output logic           last_d2,
  output logic           last_d3,
  output logic           last_d4,
  output logic [P_W-1:0] bias_d3
);

  slot_tag_e  tag_d1_r;
  slot_tag_e  tag_d2_r;
  logic [3:0] last_r;   // bit 0 = depth 1

  // Tag and last-marker shift, frozen together with the slice.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tag_d1_r <= TAG_NONE;
      tag_d2_r <= TAG_NONE;
      last_r   <= 4'b0000;
    end else if (ce) begin
      tag_d1_r <= tag_in;
      tag_d2_r <= tag_d1_r;
      last_r   <= {last_r[2:0], last_in};
    end
  end

  assign tag_d2  = tag_d2_r;
  assign last_d1 = last_r[0];
  assign last_d2 = last_r[1];
  assign last_d3 = last_r[2];
  assign last_d4 = last_r[3];

`ifdef MACC_SEQ_BIAS_EN
  logic [P_W-1:0] bias_d1_r;
  logic [P_W-1:0] bias_d2_r;
  logic [P_W-1:0] bias_d3_r;

  // Bias is captured only with the first product so C is zero elsewhere.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bias_d1_r <= {P_W{1'b0}};
      bias_d2_r <= {P_W{1'b0}};
      bias_d3_r <= {P_W{1'b0}};
    end else if (ce) begin
      bias_d1_r <= (tag_in == TAG_FIRST) ? bias_in : {P_W{1'b0}};
      bias_d2_r <= bias_d1_r;
      bias_d3_r <= bias_d2_r;
    end
  end

  assign bias_d3 = bias_d3_r;
`else
  logic unused_bias_s;
  assign unused_bias_s = ^bias_in;
  assign bias_d3       = {P_W{1'b0}};
`endif

endmodule

// File: rtl/cnn_layer_accel_macc_seq.sv
// cnn_layer_accel_macc_seq
// Sequencer for one DSP48E2 MACC slice (AREG/BREG=2, MREG=1, PREG=1,
// OPMODEREG=1, CREG=0). Turns a job length plus a stream of operand pairs
// into one dot-product result per job.
//   CLK, rst (sync, active-low)
//   cfg_len/cfg_valid/cfg_ready     - job length handshake (0 is ignored)
//   op_a/op_b/op_valid/op_ready     - operand pair stream
//   bias                            - per-job bias (MACC_SEQ_BIAS_EN only)
//   res_data/res_valid/res_ready    - registered result handshake
//   dsp_a/b/c, dsp_opmode, dsp_alumode, dsp_ce, dsp_rst -> MACC slice
//   dsp_p                           <- MACC P
// Configuration macro: MACC_SEQ_BIAS_EN.
module cnn_layer_accel_macc_seq
  import cnn_layer_accel_pkg::*;
#(
  parameter int A_W   = 30,
  parameter int B_W   = 18,
  parameter int P_W   = 48,
  parameter int LEN_W = 10
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [A_W-1:0]   op_a,
  input  logic [B_W-1:0]   op_b,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [P_W-1:0]   bias,
  output logic [P_W-1:0]   res_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [A_W-1:0]   dsp_a,
  output logic [B_W-1:0]   dsp_b,
  output logic [P_W-1:0]   dsp_c,
  output logic [8:0]       dsp_opmode,
  output logic [3:0]       dsp_alumode,
  output logic             dsp_ce,
  output logic             dsp_rst,
  input  logic [P_W-1:0]   dsp_p
);

  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  seq_state_e     state_r;
  logic [LEN_W-1:0] remain_r;
  logic           first_r;
  logic           res_valid_r;
  logic [P_W-1:0] res_data_r;

  logic           accept_s;
  logic           cfg_take_s;
  logic           res_take_s;
  slot_tag_e      tag_in_s;
  logic           last_in_s;
  slot_tag_e      tag_d2_s;
  logic           last_d1_s;
  logic           last_d2_s;
  logic           last_d3_s;
  logic           last_d4_s;
  logic [P_W-1:0] bias_d3_s;

  // A held result with no taker freezes the slice and everything feeding it.
  assign dsp_ce      = ~(res_valid_r & ~res_ready);
  assign dsp_rst     = ~rst;
  assign dsp_alumode = 4'b0000;
  assign op_ready    = (state_r == ST_RUN) & dsp_ce;
  assign accept_s    = op_valid & op_ready;
  assign res_take_s  = res_valid_r & res_ready;
  assign cfg_take_s  = cfg_valid & cfg_ready & (cfg_len != LEN_ZERO);
  assign res_valid   = res_valid_r;
  assign res_data    = res_data_r;
  assign dsp_c       = bias_d3_s;
  assign dsp_opmode  = opmode_decode(tag_d2_s);

  // Job acceptance; in DRAIN the next job may start once the last slot has
  // passed the OPMODE decode point, so it can no longer be overwritten.
  always_comb begin
    cfg_ready = 1'b0;
    case (state_r)
      ST_IDLE:  cfg_ready = 1'b1;
      ST_RUN:   cfg_ready = 1'b0;
      ST_DRAIN: cfg_ready = ~last_d1_s & ~last_d2_s;
      default:  cfg_ready = 1'b0;
    endcase
  end

  // Slot issue: operands go straight to the A1/B1 inputs; an idle RUN cycle
  // issues a zero bubble tagged HOLD so P keeps the partial sum.
  always_comb begin
    tag_in_s  = TAG_NONE;
    last_in_s = 1'b0;
    dsp_a     = {A_W{1'b0}};
    dsp_b     = {B_W{1'b0}};
    if (state_r == ST_RUN) begin
      if (accept_s) begin
        tag_in_s  = first_r ? TAG_FIRST : TAG_ACC;
        last_in_s = (remain_r == LEN_ONE);
        dsp_a     = op_a;
        dsp_b     = op_b;
      end else begin
        tag_in_s  = TAG_HOLD;
      end
    end else begin
      tag_in_s  = TAG_NONE;
    end
  end

  // Sequencer FSM and product counter.
  always_ff @(posedge CLK) begin
    if (!rst) begin
      state_r  <= ST_IDLE;
      remain_r <= LEN_ZERO;
      first_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cfg_take_s) begin
            state_r  <= ST_RUN;
            remain_r <= cfg_len;
            first_r  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (accept_s) begin
            remain_r <= remain_r - LEN_ONE;
            first_r  <= 1'b0;
            if (remain_r == LEN_ONE) begin
              state_r <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (cfg_take_s) begin
            state_r  <= ST_RUN;
            remain_r <= cfg_len;
            first_r  <= 1'b1;
          end else if (res_take_s & ~(last_d1_s | last_d2_s | last_d3_s | last_d4_s)) begin
            // Only leave once this job's own result has been taken.
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Result register: captures P when the last slot reaches it.
  always_ff @(posedge CLK) begin
    if (!rst) begin
      res_valid_r <= 1'b0;
      res_data_r  <= {P_W{1'b0}};
    end else if (dsp_ce) begin
      if (last_d4_s) begin
        res_valid_r <= 1'b1;
        res_data_r  <= dsp_p;
      end else if (res_ready) begin
        res_valid_r <= 1'b0;
      end
    end
  end

  cnn_layer_accel_macc_tag_pipe #(
    .P_W (P_W)
  ) u_tag_pipe (
    .clk     (CLK),
    .rst     (rst),
    .ce      (dsp_ce),
    .tag_in  (tag_in_s),
    .last_in (last_in_s),
    .bias_in (bias),
    .tag_d2  (tag_d2_s),
    .last_d1 (last_d1_s),
    .last_d2 (last_d2_s),
    .last_d3 (last_d3_s),
    .last_d4 (last_d4_s),
    .bias_d3 (bias_d3_s)
  );

endmodule
